// File: rtl/ram_port_master.sv
// ram_port_master
//
// Initiator for one RAM port. The RAM does either a write or a read per
// cycle and has a one-cycle registered read. Its output is held on write
// cycles. Client requests arrive on a valid/ready channel and drive the RAM
// directly. Read data comes back in request order through a 2-entry
// response FIFO, which absorbs backpressure on the response side. A bulk
// clear sequencer writes CLEAR_VALUE to addresses 0..NUM_WORDS-1.
//
// Ports:
//   clk          clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   req_valid    request present
//   req_ready    request accepted this cycle when req_valid & req_ready
//   req_we       1 = write, 0 = read
//   req_addr     request address
//   req_data     write data
//   rsp_valid    read response available (FIFO not empty)
//   rsp_ready    client takes the response
//   rsp_data     head of the response FIFO (0 when empty)
//   clear_start  start a bulk clear (only looked at in IDLE)
//   busy         high while the clear runs
//   clear_done   one-cycle pulse in the first IDLE cycle after a clear
//   ram_address  RAM address (combinational)
//   ram_wren     RAM write enable (combinational)
//   ram_data     RAM write data (combinational)
//   ram_out      RAM registered read data
module ram_port_master #(
  parameter int                AWIDTH      = 10,
  parameter int                NUM_WORDS   = 1024,
  parameter int                DWIDTH      = 32,
  parameter logic [DWIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic [AWIDTH-1:0] ram_address,
  output logic              ram_wren,
  output logic [DWIDTH-1:0] ram_data,
  input  logic [DWIDTH-1:0] ram_out
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              pend_q, pend_d;
  logic [1:0]        occ_q, occ_d;
  logic              rptr_q, rptr_d;
  logic              wptr_q, wptr_d;
  logic [DWIDTH-1:0] fifo_q [2];

  logic              push, pop, accept, rd_room;
  logic [2:0]        outstanding;

  assign rsp_valid = (occ_q != 2'd0);
  assign rsp_data  = rsp_valid ? fifo_q[rptr_q] : '0;
  assign busy      = (state_q == CLEAR);
  assign clear_done = done_q;

  assign pop  = rsp_valid & rsp_ready;
  // Data for the read accepted on the previous edge is now on ram_out.
  assign push = pend_q;

  // Reads in flight: entries already in the FIFO plus the one on ram_out.
  // A pop in the same cycle frees a slot before the new read lands two
  // edges later. That credit keeps back-to-back reads at one per cycle,
  // and the FIFO still never overflows.
  assign outstanding = 3'(occ_q) + 3'(pend_q);
  assign rd_room     = outstanding < (3'd2 + 3'(pop));

  assign req_ready = !reset && (state_q == IDLE) && !clear_start &&
                     (req_we || rd_room);
  assign accept    = req_valid & req_ready;

  always_comb begin
    pend_d = accept & ~req_we;
    occ_d  = occ_q + 2'(push) - 2'(pop);
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ pop;
  end

  // FSM next state and RAM drive
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    ram_address = req_addr;
    ram_wren    = 1'b0;
    ram_data    = req_data;
    case (state_q)
      IDLE: begin
        ram_wren = accept & req_we;
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        ram_address = cnt_q;
        ram_wren    = 1'b1;
        ram_data    = CLEAR_VALUE;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      occ_q   <= 2'd0;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      occ_q   <= occ_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
    end
  end

  // Response storage. It has no reset because occupancy gates its visibility.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= ram_out;
  end

endmodule

// File: tb/tb_ram_port_master.sv
module tb_ram_port_master;

  localparam int          AW = 6;
  localparam int          NW = 16;
  localparam int          DW = 32;
  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          clear_start, busy, clear_done;
  logic [AW-1:0] ram_address;
  logic          ram_wren;
  logic [DW-1:0] ram_data, ram_out;

  always #5 clk = ~clk;

  ram_port_master #(
    .AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_out(ram_out)
  );

  // Single-port RAM: registered read, output held on write cycles.
  logic [DW-1:0] tb_mem [64];
  always @(posedge clk) begin
    if (ram_wren) tb_mem[ram_address] <= ram_data;
    else          ram_out <= tb_mem[ram_address];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents as the client sees them, plus the
  // list of outstanding reads with the value each must return and the
  // cycle it was accepted in.
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [64];
  int          cyc = 0;
  int          clr_left = 0;
  bit          done_exp = 1'b0;

  task automatic run_scoreboard();
    bit ev, pop, ready_exp, nxt_done;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        clr_left = 0;
        done_exp = 1'b0;
      end else begin
        // A response is visible two edges after its read was accepted.
        ev  = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc - 2);
        pop = ev && rsp_ready;
        checks++;
        if (rsp_valid !== ev) begin
          errors++;
          $display("FAIL sb_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev);
        end
        if (ev) begin
          checks++;
          if (rsp_data !== exp_q[0].data) begin
            errors++;
            $display("FAIL sb_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_q[0].data);
          end
        end
        checks++;
        if (clear_done !== done_exp) begin
          errors++;
          $display("FAIL sb_clear_done cyc=%0d got=%b exp=%b", cyc, clear_done, done_exp);
        end
        checks++;
        if (busy !== (clr_left > 0)) begin
          errors++;
          $display("FAIL sb_busy cyc=%0d got=%b exp=%b", cyc, busy, clr_left > 0);
        end
        nxt_done = 1'b0;
        if (clr_left > 0) begin
          ready_exp = 1'b0;
          checks++;
          if (ram_wren !== 1'b1 || ram_address !== 6'(NW - clr_left) || ram_data !== CV) begin
            errors++;
            $display("FAIL sb_clear_write cyc=%0d got=%b/%0d/%h exp=1/%0d/%h",
                     cyc, ram_wren, ram_address, ram_data, NW - clr_left, CV);
          end
          nxt_done = (clr_left == 1);
          clr_left--;
        end else begin
          if (clear_start)  ready_exp = 1'b0;
          else if (req_we)  ready_exp = 1'b1;
          else              ready_exp = (exp_q.size() < 2 + int'(pop));
          checks++;
          if (ram_wren !== (req_valid && ready_exp && req_we) || ram_address !== req_addr) begin
            errors++;
            $display("FAIL sb_ram_drive cyc=%0d got=%b/%0d exp=%b/%0d", cyc, ram_wren,
                     ram_address, req_valid && ready_exp && req_we, req_addr);
          end
          if (clear_start) begin
            clr_left = NW;
            for (int i = 0; i < NW; i++) ref_mem[i] = CV;
          end else if (req_valid && ready_exp) begin
            if (req_we) ref_mem[req_addr] = req_data;
            else        exp_q.push_back('{data: ref_mem[req_addr], cyc: cyc});
          end
        end
        checks++;
        if (req_ready !== ready_exp) begin
          errors++;
          $display("FAIL sb_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, ready_exp);
        end
        if (pop) void'(exp_q.pop_front());
        done_exp = nxt_done;
      end
      cyc++;
    end
  endtask

  // Drives one request from posedge+1 until it is accepted and returns
  // at posedge+1 after the accepting edge.
  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    int n = 0;
    bit ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_data = d;
    while (!ok && n < 64) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0; req_we = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_timeout got=not_accepted exp=accepted addr=%0d", a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1;
    #12;
    checks += 5;
    if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    if (rsp_data !== '0)     begin errors++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (clear_done !== 1'b0) begin errors++; $display("FAIL rst_clear_done got=%b exp=0", clear_done); end
    if (req_ready !== 1'b0)  begin errors++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1;
    req_we = 1'b0;
  endtask

  task automatic test_preload();
    for (int i = 0; i < 64; i++) issue(1'b1, 6'(i), $urandom);
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    issue(1'b1, 6'd5, 32'hDEADBEEF);
    issue(1'b0, 6'd5, 32'h0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_early got=%b exp=0", rsp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 2;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_valid got=%b exp=1", rsp_valid); end
    if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data got=%h exp=deadbeef", rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    issue(1'b1, 6'd1, 32'h11);
    issue(1'b1, 6'd2, 32'h22);
    issue(1'b1, 6'd3, 32'h33);
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_rd1_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1; req_addr = 6'd2;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_rd2_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1; req_addr = 6'd3;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got=%b exp=0", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 3;
    if (req_ready !== 1'b0)     begin errors++; $display("FAIL bp_ready_full got=%b exp=0", req_ready); end
    if (rsp_valid !== 1'b1)     begin errors++; $display("FAIL bp_rsp_valid got=%b exp=1", rsp_valid); end
    if (rsp_data !== 32'h11)    begin errors++; $display("FAIL bp_head got=%h exp=11", rsp_data); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_data !== 32'h11)    begin errors++; $display("FAIL bp_head_hold got=%h exp=11", rsp_data); end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_third_accept got=%b exp=1", req_ready); end
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = 6'($urandom);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, req_ready); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_clear();
    clear_start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy_pre got=%b exp=0", busy); end
    @(posedge clk); #1; clear_start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || ram_wren !== 1'b1 || ram_address !== 6'(i) || clear_done !== 1'b0) begin
        errors++;
        $display("FAIL clr_cycle i=%0d got=%b/%b/%0d/%b exp=1/1/%0d/0", i, busy, ram_wren,
                 ram_address, clear_done, i);
      end
      @(posedge clk); #1;
      clear_start = (i == 3);
    end
    clear_start = 1'b0;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0)       begin errors++; $display("FAIL clr_busy_end got=%b exp=0", busy); end
    if (clear_done !== 1'b1) begin errors++; $display("FAIL clr_done_pulse got=%b exp=1", clear_done); end
    @(posedge clk); #1;
    @(negedge clk);
    checks += 2;
    if (clear_done !== 1'b0) begin errors++; $display("FAIL clr_done_once got=%b exp=0", clear_done); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL clr_restart got=%b exp=0", busy); end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(1'b0, 6'd15, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== CV) begin
      errors++; $display("FAIL clr_readback got=%b/%h exp=1/%h", rsp_valid, rsp_data, CV);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_vs_write();
    logic [31:0] d;
    d = $urandom;
    clear_start = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd20; req_data = d;
    @(negedge clk);
    checks += 2;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL cvw_ready got=%b exp=0", req_ready); end
    if (ram_wren !== 1'b0)  begin errors++; $display("FAIL cvw_wren got=%b exp=0", ram_wren); end
    @(posedge clk); #1; clear_start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL cvw_ready_clear i=%0d got=%b exp=0", i, req_ready); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || ram_wren !== 1'b1 || ram_address !== 6'd20) begin
      errors++; $display("FAIL cvw_accept_after got=%b/%b/%0d exp=1/1/20", req_ready, ram_wren, ram_address);
    end
    @(posedge clk); #1; req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    issue(1'b0, 6'd20, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_data !== d) begin errors++; $display("FAIL cvw_readback got=%h exp=%h", rsp_data, d); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_then_clear();
    logic [31:0] v;
    int n = 0;
    v = $urandom;
    rsp_ready = 1'b1;
    issue(1'b1, 6'd7, v);
    rsp_ready = 1'b0;
    issue(1'b0, 6'd7, 32'h0);
    clear_start = 1'b1;
    @(posedge clk); #1; clear_start = 1'b0;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL rtc_busy got=%b exp=1", busy); end
    if (rsp_valid !== 1'b1 || rsp_data !== v) begin
      errors++; $display("FAIL rtc_data got=%b/%h exp=1/%h", rsp_valid, rsp_data, v);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rtc_drain got=%b/%b exp=0/1", rsp_valid, busy);
    end
    while (busy && n < 32) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rtc_timeout got=busy exp=idle"); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_clear();
    rsp_ready = 1'b0;
    issue(1'b0, 6'd20, 32'h0);
    clear_start = 1'b1;
    @(posedge clk); #1; clear_start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd30; req_data = $urandom;
    #1;
    checks += 6;
    if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL rmc_rsp_valid got=%b exp=0", rsp_valid); end
    if (rsp_data !== '0)     begin errors++; $display("FAIL rmc_rsp_data got=%h exp=0", rsp_data); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rmc_busy got=%b exp=0", busy); end
    if (clear_done !== 1'b0) begin errors++; $display("FAIL rmc_clear_done got=%b exp=0", clear_done); end
    if (req_ready !== 1'b0)  begin errors++; $display("FAIL rmc_req_ready got=%b exp=0", req_ready); end
    if (ram_wren !== 1'b0)   begin errors++; $display("FAIL rmc_wren got=%b exp=0", ram_wren); end
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (req_ready !== 1'b1)  begin errors++; $display("FAIL rmc_write_ready got=%b exp=1", req_ready); end
    if (clear_done !== 1'b0) begin errors++; $display("FAIL rmc_no_done got=%b exp=0", clear_done); end
    @(posedge clk); #1; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_valid   = 1'($urandom);
      req_we      = 1'($urandom);
      req_addr    = 6'($urandom);
      req_data    = $urandom;
      rsp_ready   = (($urandom % 4) != 0);
      clear_start = (($urandom % 50) == 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; clear_start = 1'b0; rsp_ready = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rnd_quiesce got=%b/%b exp=0/0", rsp_valid, busy);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b0; clear_start = 1'b0;
    fork
      run_scoreboard();
    join_none
    test_reset();
    test_preload();
    test_write_read();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_clear_vs_write();
    test_read_then_clear();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
